// File: rtl/seg7_scan_drv.sv
`timescale 1ns/1ps
// Six-digit multiplexed 7-seg driver (active-low); outputs lag scan state by 1 cycle, new words apply at frame boundary.
// Back-pressure: in_ready low while a word is pending; it frees at the next frame boundary.
module seg7_scan_drv #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int BLANK_CYC = 16,
    parameter int LZ_BLANK  = 1
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    input  logic [31:0] indata_24bit,
    input  logic [5:0]  dp_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  seg_n,
    output logic [5:0]  dig_n,
    output logic        frame_done
);
    localparam int TICK_MAX = CLK_HZ / SCAN_HZ - 1;
    localparam int CW       = (TICK_MAX > 1) ? $clog2(TICK_MAX + 1) : 1;
    localparam logic [CW-1:0] TICK_MAX_C = CW'(TICK_MAX);
    localparam logic [CW-1:0] BLANK_C    = CW'(BLANK_CYC);

    logic [CW-1:0] r_tick_cnt;
    logic [2:0]    r_idx;
    logic [23:0]   r_disp_dat;
    logic [5:0]    r_disp_dp;
    logic [23:0]   r_pend_dat;
    logic [5:0]    r_pend_dp;
    logic          r_pend_full;
    logic [7:0]    r_seg_n;
    logic [5:0]    r_dig_n;
    logic          r_frame_done;

    logic          w_tick;
    logic          w_frame;
    logic [3:0]    w_nib;
    logic [6:0]    w_hex;
    logic [5:0]    w_lz;
    logic          w_blank;
    logic          w_unused;

    assign w_unused = &{1'b0, indata_24bit[31:24]};
    assign w_tick   = (r_tick_cnt == TICK_MAX_C);
    assign w_frame  = w_tick && (r_idx == 3'd5);
    assign w_nib    = r_disp_dat[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_hex = 7'h7F;
        case (w_nib)
            4'h0: w_hex = 7'h40;
            4'h1: w_hex = 7'h79;
            4'h2: w_hex = 7'h24;
            4'h3: w_hex = 7'h30;
            4'h4: w_hex = 7'h19;
            4'h5: w_hex = 7'h12;
            4'h6: w_hex = 7'h02;
            4'h7: w_hex = 7'h78;
            4'h8: w_hex = 7'h00;
            4'h9: w_hex = 7'h10;
            4'hA: w_hex = 7'h08;
            4'hB: w_hex = 7'h03;
            4'hC: w_hex = 7'h46;
            4'hD: w_hex = 7'h21;
            4'hE: w_hex = 7'h06;
            4'hF: w_hex = 7'h0E;
            default: w_hex = 7'h7F;
        endcase
    end

    // w_lz[k]: nibble k and all higher nibbles are zero; digit 0 always shown
    always_comb begin
        w_lz    = 6'b0;
        w_lz[5] = (r_disp_dat[23:20] == 4'h0);
        for (int k = 4; k >= 1; k--)
            w_lz[k] = w_lz[k+1] && (r_disp_dat[k*4 +: 4] == 4'h0);
        w_lz[0] = 1'b0;
        w_blank = (LZ_BLANK != 0) && w_lz[r_idx];
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_tick_cnt   <= '0;
            r_idx        <= 3'd0;
            r_disp_dat   <= 24'h0;
            r_disp_dp    <= 6'h0;
            r_pend_dat   <= 24'h0;
            r_pend_dp    <= 6'h0;
            r_pend_full  <= 1'b0;
            r_seg_n      <= 8'hFF;
            r_dig_n      <= 6'h3F;
            r_frame_done <= 1'b0;
        end else begin
            r_tick_cnt   <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick)
                r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            r_frame_done <= w_frame;

            // Capture is only possible with pending empty, so it never collides with the swap
            if (w_frame && r_pend_full) begin
                r_disp_dat  <= r_pend_dat;
                r_disp_dp   <= r_pend_dp;
                r_pend_full <= 1'b0;
            end else if (in_valid && !r_pend_full) begin
                r_pend_dat  <= indata_24bit[23:0];
                r_pend_dp   <= dp_in;
                r_pend_full <= 1'b1;
            end

            if (r_tick_cnt < BLANK_C) begin
                r_seg_n <= 8'hFF;
                r_dig_n <= 6'h3F;
            end else begin
                r_seg_n <= {~r_disp_dp[r_idx], w_blank ? 7'h7F : w_hex};
                r_dig_n <= ~(6'b000001 << r_idx);
            end
        end
    end

    assign in_ready   = !r_pend_full;
    assign seg_n      = r_seg_n;
    assign dig_n      = r_dig_n;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_seg7_scan_drv.sv
`timescale 1ns/1ps
// Bench for seg7_scan_drv: 10-cycle slots, 2 ghost cycles, 60-cycle frames, compared against a slot/frame arithmetic model.
module tb_seg7_scan_drv;
    logic        CLOCK_50 = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] indata_24bit = '0;
    logic [5:0]  dp_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  seg_n;
    logic [5:0]  dig_n;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model: n = clock edges since reset release
    int          m_n = 0;
    logic [23:0] m_disp = '0;
    logic [5:0]  m_dp = '0;
    logic [23:0] m_pend = '0;
    logic [5:0]  m_pend_dp = '0;
    logic        m_full = 1'b0;
    logic        m_last_fd = 1'b0;

    seg7_scan_drv #(.CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(2), .LZ_BLANK(1)) dut (
        .CLOCK_50(CLOCK_50), .rst(rst), .indata_24bit(indata_24bit), .dp_in(dp_in),
        .in_valid(in_valid), .in_ready(in_ready), .seg_n(seg_n), .dig_n(dig_n),
        .frame_done(frame_done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [7:0] hex_code(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
            4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
            4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
            4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input logic [23:0] w, input logic [5:0] dp, input int k);
        logic [7:0] s;
        s = hex_code(w[k*4 +: 4]);
        if (k > 0 && (w >> (4 * k)) == 24'h0) s = 8'hFF;
        if (dp[k]) s[7] = 1'b0;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance model, check every output 1ns after the edge
    task automatic step(input logic v, input logic [31:0] d, input logic [5:0] p, input logic r);
        int cnt, idx;
        logic [7:0] e_seg;
        logic [5:0] e_dig;
        logic       e_fd;
        rst = r; in_valid = v; indata_24bit = d; dp_in = p;
        cnt = m_n % 10;
        idx = (m_n / 10) % 6;
        if (r) begin
            e_seg = 8'hFF; e_dig = 6'h3F; e_fd = 1'b0;
            m_n = 0; m_disp = '0; m_dp = '0; m_full = 1'b0;
        end else begin
            if (cnt < 2) begin
                e_seg = 8'hFF; e_dig = 6'h3F;
            end else begin
                e_seg = exp_seg(m_disp, m_dp, idx);
                e_dig = ~(6'b000001 << idx);
            end
            e_fd = (cnt == 9 && idx == 5);
            if (e_fd && m_full) begin
                m_disp = m_pend; m_dp = m_pend_dp; m_full = 1'b0;
            end else if (v && !m_full) begin
                m_pend = d[23:0]; m_pend_dp = p; m_full = 1'b1;
            end
            m_n++;
        end
        m_last_fd = e_fd;
        @(posedge CLOCK_50);
        #1;
        in_valid = 1'b0;
        chk("seg_n", seg_n, e_seg);
        chk("dig_n", {2'b0, dig_n}, {2'b0, e_dig});
        chk("frame_done", {7'b0, frame_done}, {7'b0, e_fd});
        chk("in_ready", {7'b0, in_ready}, {7'b0, !m_full});
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 6'h0, 1'b0);
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 80; i++) begin
            idle();
            if (m_last_fd) return;
        end
        chk("wait_frame_timeout", 8'd0, 8'd1);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 80; i++) begin
            if (!m_full) return;
            idle();
        end
        chk("wait_ready_timeout", 8'd0, 8'd1);
    endtask

    // Mid-slot sample of digit d with explicit constant expectations
    task automatic check_digit(input int d, input logic [7:0] exp, input string tag);
        for (int i = 0; i < 80; i++) begin
            if ((m_n / 10) % 6 == d && m_n % 10 == 5) begin
                idle();
                chk(tag, seg_n, exp);
                chk({tag, "_dig"}, {2'b0, dig_n}, {2'b0, ~(6'b000001 << d)});
                return;
            end
            idle();
        end
        chk({tag, "_timeout"}, 8'd0, 8'd1);
    endtask

    initial begin
        // Reset
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 6'h0, 1'b1);
        chk("rst_in_ready", {7'b0, in_ready}, 8'd1);
        chk("rst_seg", seg_n, 8'hFF);
        check_digit(0, 8'hC0, "rst_d0");
        for (int k = 1; k < 6; k++) check_digit(k, 8'hFF, "rst_dk");

        // Load word: nibble k drives digit k, dp on digit 2
        step(1'b1, 32'h00123456, 6'b000100, 1'b0);
        chk("load_rdy_drop", {7'b0, in_ready}, 8'd0);
        wait_frame();
        chk("load_fd", {7'b0, frame_done}, 8'd1);
        chk("load_rdy_back", {7'b0, in_ready}, 8'd1);
        check_digit(0, 8'h82, "load_d0");
        check_digit(1, 8'h92, "load_d1");
        check_digit(2, 8'h19, "load_d2");
        check_digit(3, 8'hB0, "load_d3");
        check_digit(4, 8'hA4, "load_d4");
        check_digit(5, 8'hF9, "load_d5");

        // Back-pressure: B offered while A pending is dropped
        wait_ready();
        step(1'b1, 32'h0000000A, 6'h0, 1'b0);
        step(1'b1, 32'h00000007, 6'h0, 1'b0);
        wait_frame();
        check_digit(0, 8'h88, "bp_A");
        wait_ready();
        step(1'b1, 32'h00000007, 6'h0, 1'b0);
        wait_frame();
        check_digit(0, 8'hF8, "bp_B");

        // Boundary collision: capture on the boundary tick goes to pending only
        wait_ready();
        for (int i = 0; i < 80 && (m_n % 60) != 59; i++) idle();
        step(1'b1, 32'h0000000C, 6'h0, 1'b0);
        chk("coll_rdy", {7'b0, in_ready}, 8'd0);
        check_digit(0, 8'hF8, "coll_old");
        check_digit(0, 8'hC6, "coll_new");

        // Reset mid-operation discards the pending word
        wait_ready();
        step(1'b1, 32'h00FFFFFF, 6'h0, 1'b0);
        for (int i = 0; i < 3; i++) idle();
        step(1'b0, 32'h0, 6'h0, 1'b1);
        idle();
        chk("mrst_rdy", {7'b0, in_ready}, 8'd1);
        check_digit(0, 8'hC0, "mrst_d0");
        check_digit(1, 8'hFF, "mrst_d1");

        // Randomized traffic with sparse resets
        for (int i = 0; i < 2000; i++) begin
            logic v, r;
            logic [31:0] d;
            v = ($urandom % 6 == 0);
            r = ($urandom % 700 == 0);
            d = $urandom >> $urandom_range(0, 31);
            step(v, d, 6'($urandom), r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
